// File: rtl/alu_arbiter_if.sv
// Requester/consumer bundle for alu_arbiter: NREQ request lanes in, one
// tagged result lane out. The master side is the requesters plus the
// result consumer; the slave side is the arbiter.
interface alu_arbiter_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned NREQ  = 2
);
  localparam int unsigned IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned FNW = 3;

  logic [NREQ-1:0]            req_valid;
  logic [NREQ-1:0]            req_ready;
  logic [NREQ-1:0][FNW-1:0]   req_fn;
  logic [NREQ-1:0][6:0]       req_funct7;
  logic [NREQ-1:0][WIDTH-1:0] req_a;
  logic [NREQ-1:0][WIDTH-1:0] req_b;

  logic                       rsp_valid;
  logic                       rsp_ready;
  logic [IDW-1:0]             rsp_id;
  logic [WIDTH-1:0]           rsp_data;
  logic                       busy;

  modport master (
    output req_valid, req_fn, req_funct7, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data, busy
  );

  modport slave (
    input  req_valid, req_fn, req_funct7, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data, busy
  );
endinterface

// File: rtl/alu_arbiter.sv
// Shared-ALU arbiter: one combinational alu time-shared among NREQ
// requesters with round-robin grant and a single registered result slot.

package alu_pkg;
  // Function codes follow the RISC-V funct3 numbering of the OP group.
  typedef enum logic [2:0] {
    ADD_SUB = 3'd0,
    SLL     = 3'd1,
    SLT     = 3'd2,
    SLTU    = 3'd3,
    XOR     = 3'd4,
    SRL_SRA = 3'd5,
    OR      = 3'd6,
    AND     = 3'd7
  } ALU_FN_t;
endpackage

// Combinational integer ALU; funct7 != 0 selects SUB / SRA.
module alu
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  ALU_FN_t          fn,
  input  logic [6:0]       funct7,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] out
);
  localparam int unsigned SHW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic           alt;
  logic [SHW-1:0] shamt;

  assign alt   = (funct7 != 7'd0);
  assign shamt = b[SHW-1:0];

  // Operation select; every path assigns out.
  always_comb begin
    out = '0;
    case (fn)
      ADD_SUB: out = alt ? (a - b) : (a + b);
      SLL:     out = a << shamt;
      SLT:     out = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      SLTU:    out = {{(WIDTH-1){1'b0}}, (a < b)};
      XOR:     out = a ^ b;
      SRL_SRA: out = alt ? WIDTH'($signed(a) >>> shamt) : (a >> shamt);
      OR:      out = a | b;
      AND:     out = a & b;
      default: out = '0;
    endcase
  end
endmodule

module alu_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned NREQ  = 2
) (
  input  logic         clk,
  input  logic         rst,
  alu_arbiter_if.slave bus
);
  localparam int unsigned IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} slot_state_t;

  slot_state_t      state;
  logic [IDW-1:0]   rr_ptr;
  logic [IDW-1:0]   rsp_id_q;
  logic [WIDTH-1:0] rsp_data_q;

  logic             found;
  logic [IDW-1:0]   grant;
  logic [IDW-1:0]   idx;
  logic             can_accept;
  logic             accept;
  logic [NREQ-1:0]  ready_vec;

  ALU_FN_t          alu_fn;
  logic [6:0]       alu_funct7;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [WIDTH-1:0] alu_out;

  // Round-robin search: first valid requester at or after rr_ptr, wrapping.
  always_comb begin
    found = 1'b0;
    grant = '0;
    idx   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = IDW'((32'(rr_ptr) + k) % NREQ);
      if (!found && bus.req_valid[idx]) begin
        found = 1'b1;
        grant = idx;
      end
    end
  end

  // Handshake: only the granted lane sees ready, and only when the slot can
  // take a result this edge (empty, or being drained simultaneously).
  always_comb begin
    can_accept = (state == EMPTY) || bus.rsp_ready;
    accept     = found && can_accept && !rst;
    ready_vec  = '0;
    if (accept) begin
      ready_vec[grant] = 1'b1;
    end
  end

  // Operand mux from the granted lane into the shared ALU.
  always_comb begin
    alu_fn     = ALU_FN_t'(bus.req_fn[grant]);
    alu_funct7 = bus.req_funct7[grant];
    alu_a      = bus.req_a[grant];
    alu_b      = bus.req_b[grant];
  end

  alu #(
    .WIDTH(WIDTH)
  ) u_alu (
    .fn    (alu_fn),
    .funct7(alu_funct7),
    .a     (alu_a),
    .b     (alu_b),
    .out   (alu_out)
  );

  // Result slot FSM with its payload and the round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= EMPTY;
      rsp_data_q <= '0;
      rsp_id_q   <= '0;
      rr_ptr     <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            state <= FULL;
          end
        end
        FULL: begin
          if (bus.rsp_ready && !accept) begin
            state <= EMPTY;
          end
        end
        default: state <= EMPTY;
      endcase
      if (accept) begin
        rsp_data_q <= alu_out;
        rsp_id_q   <= grant;
        rr_ptr     <= IDW'((32'(grant) + 32'd1) % NREQ);
      end
    end
  end

  assign bus.req_ready = ready_vec;
  assign bus.rsp_valid = (state == FULL);
  assign bus.busy      = (state == FULL);
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_data  = rsp_data_q;
endmodule
